// File: rtl/dark_wrbuf.sv
// Posted-write buffer between the darkriscv data port and on-chip memory.
// Stores are queued and retired in order; loads wait for the queue to drain.
module dark_wrbuf #(
    parameter int DEPTH = 4
) (
    input  logic                    XCLK,
    input  logic                    XRES,
    input  logic                    c_rd,
    input  logic                    c_wr,
    input  logic [3:0]              c_be,
    input  logic [31:0]             c_addr,
    input  logic [31:0]             c_wdata,
    output logic [31:0]             c_rdata,
    output logic                    c_halt,
    output logic                    m_en,
    output logic                    m_rd,
    output logic                    m_wr,
    output logic [3:0]              m_be,
    output logic [31:0]             m_addr,
    output logic [31:0]             m_wdata,
    input  logic [31:0]             m_rdata,
    input  logic                    m_ack,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } wr_ent_t;

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    wr_ent_t        fifo_q [DEPTH];
    wr_ent_t        head;
    logic [AW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;
    state_t         state_q, state_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [31:0]    raddr_q, raddr_d;
    logic [3:0]     rbe_q, rbe_d;
    logic           full, push, pop;

    assign full  = (count_q == CW'(DEPTH));
    assign push  = c_wr & ~full;
    assign pop   = (state_q == WRITE) & m_ack;
    assign head  = fifo_q[head_q];
    assign count = count_q;
    assign c_rdata = rdata_q;
    assign c_halt  = (c_wr & full) | (c_rd & (state_q != RESP));

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        rdata_d = rdata_q;
        raddr_d = raddr_q;
        rbe_d   = rbe_q;

        if (push) tail_d = tail_q + AW'(1);
        if (pop)  head_d = head_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                // a push this cycle counts as queued so the write starts next cycle
                if (count_q != '0 || push) begin
                    state_d = WRITE;
                end else if (c_rd) begin
                    state_d = READ;
                    raddr_d = c_addr;
                    rbe_d   = c_be;
                end
            end
            WRITE: begin
                if (m_ack) state_d = (count_q > CW'(1) || push) ? WRITE : IDLE;
            end
            READ: begin
                if (m_ack) begin
                    rdata_d = m_rdata;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // memory side is decoded purely from registers; the load address is latched on entry to READ
    always_comb begin
        m_en    = 1'b0;
        m_rd    = 1'b0;
        m_wr    = 1'b0;
        m_be    = '0;
        m_addr  = '0;
        m_wdata = '0;
        case (state_q)
            WRITE: begin
                m_en    = 1'b1;
                m_wr    = 1'b1;
                m_be    = head.be;
                m_addr  = head.addr;
                m_wdata = head.data;
            end
            READ: begin
                m_en   = 1'b1;
                m_rd   = 1'b1;
                m_be   = rbe_q;
                m_addr = raddr_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge XCLK or posedge XRES) begin
        if (XRES) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            rdata_q <= '0;
            raddr_q <= '0;
            rbe_q   <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
            raddr_q <= raddr_d;
            rbe_q   <= rbe_d;
        end
    end

    always_ff @(posedge XCLK) begin
        if (push) fifo_q[tail_q] <= {c_addr, c_be, c_wdata};
    end
endmodule
